// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host frame receiver with E0/F0 prefix folding
// Optional PS2_PARITY_CHECK_EN: when defined, odd-parity mismatches discard the frame.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       code_ready,
    output logic [9:0] scan_code,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall;
    logic          dat_f;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_q, brk_q;
    logic          timeout;
    logic          par_ok;
    logic          byte_ok;
    logic          err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {ps2_dat_i, ps2_clk_i};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FILT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign fall  = clk_prev_q & ~filt_q[0];
    assign dat_f = filt_q[1];

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (fall && state_q == S_PARITY) begin
            par_q <= dat_f;
        end
    end

    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_ok = 1'b0;
        err     = 1'b0;
        timeout = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);
        if (timeout) begin
            state_d = S_IDLE;
            err     = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_f) begin
                        state_d = S_DATA;
                    end else begin
                        err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_f && par_ok) begin
                        byte_ok = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_ready <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= '0;
        end else begin
            clk_prev_q <= filt_q[0];
            code_ready <= 1'b0;
            frame_err  <= err;

            if (fall || state_q == S_IDLE) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (fall && state_q == S_IDLE) begin
                bit_cnt_q <= '0;
            end
            if (fall && state_q == S_DATA) begin
                shift_q   <= {dat_f, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            // Prefixes only arm flags; any other good byte consumes them.
            if (err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_ok) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    scan_code  <= {ext_q, brk_q, shift_q};
                    code_ready <= 1'b1;
                    ext_q      <= 1'b0;
                    brk_q      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

    localparam int FL   = 8;
    localparam int TO   = 1500;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       code_ready;
    logic [9:0] scan_code;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int both_cnt = 0;
    int chg_bad  = 0;

    // Event encoding: {is_error, scan_code}
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic [9:0]  last_code = '0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .code_ready (code_ready),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_ready) obs_q.push_back({1'b0, scan_code});
            if (frame_err) obs_q.push_back({1'b1, 10'h000});
            if (code_ready && frame_err) both_cnt++;
            if (scan_code !== last_code && !code_ready) chg_bad++;
        end
        last_code = scan_code;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_dat_i = b;
        if (glitch) begin
            idle(10);
            ps2_clk_i = 1'b0;
            idle(3);
            ps2_clk_i = 1'b1;
            idle(HALF - 13);
        end else begin
            idle(HALF);
        end
        ps2_clk_i = 1'b0;
        idle(HALF);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input bit glitch);
        logic p;
        p = (~^d) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(p, glitch);
        send_bit(stop, glitch);
        ps2_dat_i = 1'b1;
        idle(2 * HALF);
    endtask

    task automatic expect_code(input logic [9:0] c);
        exp_q.push_back({1'b0, c});
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b1, 10'h000});
    endtask

    task automatic drain(input string name);
        int t;
        logic [10:0] e, o;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        idle(100);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL %s event_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        else
            n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL %s missing_event: got none required %h", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL %s event: got %h required %h", name, o, e);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(4);
        n_checks++;
        if ({code_ready, frame_err, scan_code} !== 12'h000)
            $display("FAIL reset_outputs: got %h required 000", {code_ready, frame_err, scan_code});
        else n_pass++;
        reset = 1'b0;
        idle(20);
        n_checks++;
        if ({code_ready, frame_err, scan_code} !== 12'h000)
            $display("FAIL post_reset_outputs: got %h required 000", {code_ready, frame_err, scan_code});
        else n_pass++;
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 0, 1, 0);
        expect_code(10'h01C);
        drain("basic_1c");
    endtask

    task automatic test_prefix();
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h1C, 0, 1, 0);
        expect_code(10'h11C);
        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h75, 0, 1, 0);
        expect_code(10'h375);
        send_frame(8'h75, 0, 1, 0);
        expect_code(10'h075);
        drain("prefix");
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
`else
        expect_code(10'h01C);
`endif
        drain("parity");
    endtask

    task automatic test_bad_start_stop();
        send_bit(1'b1, 0);
        idle(2 * HALF);
        expect_err();
        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'h1C, 0, 0, 0);
        expect_err();
        send_frame(8'h75, 0, 1, 0);
        expect_code(10'h075);
        drain("bad_start_stop");
    endtask

    task automatic test_timeout();
        send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        ps2_dat_i = 1'b1;
        idle(TO + 10);
        expect_err();
        send_frame(8'h5A, 0, 1, 0);
        expect_code(10'h05A);
        drain("timeout");
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 3; k++) begin
            ps2_clk_i = 1'b0;
            idle(3);
            ps2_clk_i = 1'b1;
            idle(20);
        end
        send_frame(8'h1C, 0, 1, 1);
        expect_code(10'h01C);
        drain("glitch");
    endtask

    task automatic test_reset_mid();
        send_frame(8'hE0, 0, 1, 0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({code_ready, frame_err, scan_code} !== 12'h000)
                $display("FAIL reset_mid_outputs: got %h required 000", {code_ready, frame_err, scan_code});
            else n_pass++;
        end
        reset = 1'b0;
        idle(10);
        send_frame(8'h75, 0, 1, 0);
        expect_code(10'h075);
        drain("reset_mid");
    endtask

    task automatic test_invariants();
        n_checks++;
        if (both_cnt != 0) $display("FAIL both_pulses: got %0d required 0", both_cnt);
        else n_pass++;
        n_checks++;
        if (chg_bad != 0) $display("FAIL scan_code_stable: got %0d changes required 0", chg_bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_parity();
        test_bad_start_stop();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
